div_iter: RTL and testbench

- Sequential radix-2 restoring divider, the inverse companion of the combinational Booth multiplier in the CPU execute stage.
- Accepts a WIDTH-bit dividend and divisor, signed or unsigned, and produces quotient and remainder after a fixed multicycle latency.
- A start/busy/done handshake lets the pipeline stall the EX stage while a division is in flight.

---
 rtl/div_iter.sv | 174 +++++++++++++++++
 tb/tb_div_iter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Sequential radix-2 restoring divider for the EX stage. Accepts a
//             WIDTH-bit dividend/divisor (signed or unsigned) and returns the
//             quotient (truncated toward zero) and the remainder (sign follows
//             the dividend) after WIDTH+1 cycles, using a start/busy/done
//             handshake.
//  Revision : 1.0  initial release
//
//  Optional : `define DIV_ZERO_FAST_EN -> a zero divisor skips the iterative
//             phase and produces its result one cycle after acceptance.
//
//  Ports    : clk         system clock (rising edge)
//             rstn        asynchronous active-low reset
//             start       request pulse, sampled in IDLE
//             signed_op   1 = two's-complement division, 0 = unsigned
//             dividend    dividend operand  [WIDTH]
//             divisor     divisor operand   [WIDTH]
//             busy        a division is in flight
//             done        one-cycle result-valid pulse
//             quotient    result quotient   [WIDTH]
//             remainder   result remainder  [WIDTH]
//             div_by_zero divisor was zero (valid with done)
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quot_out_q;
    logic [WIDTH-1:0]   rem_out_q;
    logic               dbz_q;

    // Working registers: rem_q is the partial remainder, dvd_q starts as the
    // magnitude of the dividend and shifts quotient bits in from the LSB.
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               zero_q;

    logic [WIDTH-1:0]   dividend_abs_d;
    logic [WIDTH-1:0]   divisor_abs_d;
    logic [WIDTH:0]     shift_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   quot_fix_d;
    logic [WIDTH-1:0]   rem_fix_d;

    always_comb begin
        // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits when read as unsigned.
        dividend_abs_d = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs_d  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

        shift_d = {rem_q, dvd_q[WIDTH-1]};
        // The restoring invariant keeps shift_d < 2*divisor, so the difference
        // lies in (-2^WIDTH, 2^WIDTH) and bit WIDTH is a valid sign bit.
        diff_d  = shift_d - {1'b0, dvs_q};

        // A zero divisor keeps the natural all-ones quotient unsigned; the
        // remainder sign fix restores the original dividend.
        quot_fix_d = zero_q ? {WIDTH{1'b1}} : (qneg_q ? -dvd_q : dvd_q);
        rem_fix_d  = rneg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_q      <= 1'b0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvd_q   <= dividend_abs_d;
                        dvs_q   <= divisor_abs_d;
                        qneg_q  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_q  <= signed_op & dividend[WIDTH-1];
                        zero_q  <= (divisor == '0);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            // Remainder register preloaded with what the
                            // iterations would have produced.
                            rem_q   <= dividend_abs_d;
                            state_q <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            state_q <= S_CALC;
                        end
`else
                        rem_q   <= '0;
                        state_q <= S_CALC;
`endif
                    end
                end

                S_CALC: begin
                    rem_q <= diff_d[WIDTH] ? shift_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], ~diff_d[WIDTH]};
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    // First DONE cycle publishes the result; the second closes
                    // the pulse and releases busy, so start is never accepted
                    // while done is high.
                    if (!done_q) begin
                        done_q     <= 1'b1;
                        quot_out_q <= quot_fix_d;
                        rem_out_q  <= rem_fix_d;
                        dbz_q      <= zero_q;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_iter
//  Purpose  : Self-checking bench for div_iter (WIDTH=32). Directed vectors,
//             randomized operations against an arithmetic reference model,
//             start-while-busy, back-to-back and mid-operation reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_iter;

    localparam int W     = 32;
    localparam int LIMIT = 100;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 64-bit values (truncating
    // division, remainder takes the dividend's sign).
    function automatic void model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        z = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
            return;
        end
        if (sop) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 1;
`endif
        return W + 1;
    endfunction

    // Drives one division and collects what the DUT reports. lat = number of
    // rising edges after the accepting edge until done is seen (-1 on timeout).
    // restart_at > 0 re-pulses start (different operands) in that cycle.
    task automatic run_div(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int restart_at,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                           output int lat, output logic busy_ok, output logic after_ok);
        @(negedge clk);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busy_ok = 1'b1;
        after_ok = 1'b0;
        lat     = -1;
        q = '0; r = '0; z = 1'b0;
        for (int i = 1; i <= LIMIT; i++) begin
            if (i == restart_at) begin
                start     = 1'b1;
                signed_op = ~sop;
                dividend  = $urandom;
                divisor   = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = i;
                q   = quotient;
                r   = remainder;
                z   = div_by_zero;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            after_ok = !done && !busy;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h z=%b, expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic         t_s [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] t_a [7] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000,
                                  32'h8000_0000, 32'h1234_5678, 32'hFFFF_FF9C};
        logic [W-1:0] t_b [7] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [W-1:0] t_q [7] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000,
                                  32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] t_r [7] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0,
                                  32'h8000_0000, 32'h1234_5678, 32'hFFFF_FF9C};
        logic         t_z [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] q, r;
        logic         z, bok, aok;
        int           lat;
        for (int i = 0; i < 7; i++) begin
            run_div(t_s[i], t_a[i], t_b[i], 0, q, r, z, lat, bok, aok);
            n_cmp++;
            if (lat !== exp_lat(t_b[i])) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat(t_b[i]));
            end
            n_cmp++;
            if ({q, r, z} !== {t_q[i], t_r[i], t_z[i]}) begin
                n_fail++;
                $display("FAIL dir%0d_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         i, q, r, z, t_q[i], t_r[i], t_z[i]);
            end
            n_cmp++;
            if ({bok, aok} !== 2'b11) begin
                n_fail++;
                $display("FAIL dir%0d_handshake: got busy_held=%b single_pulse=%b expected 1 1",
                         i, bok, aok);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic         s, z, ez, bok, aok;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = '1;
                3:       begin b = W'($urandom_range(1, 300)); a = 32'h8000_0000; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(s, a, b, eq, er, ez);
            run_div(s, a, b, 0, q, r, z, lat, bok, aok);
            n_cmp++;
            if ({q, r, z} !== {eq, er, ez} || lat !== exp_lat(b) || {bok, aok} !== 2'b11) begin
                n_fail++;
                $display("FAIL rand%0d s=%b %h/%h: got q=%h r=%h z=%b lat=%0d hs=%b%b expected q=%h r=%h z=%b lat=%0d hs=11",
                         i, s, a, b, q, r, z, lat, bok, aok, eq, er, ez, exp_lat(b));
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] q, r, eq, er;
        logic         z, ez, bok, aok;
        int           lat, extra;
        model(1'b0, 32'd1000, 32'd33, eq, er, ez);
        run_div(1'b0, 32'd1000, 32'd33, 5, q, r, z, lat, bok, aok);
        n_cmp++;
        if ({q, r, z} !== {eq, er, ez} || lat !== W + 1) begin
            n_fail++;
            $display("FAIL busy_restart_result: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=%0d",
                     q, r, z, lat, eq, er, ez, W + 1);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_restart_no_second_op: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r, eq, er;
        logic         z, ez, bok, aok;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = W'($urandom_range(1, 1000));
            model(1'b1, a, b, eq, er, ez);
            // run_div resumes in the IDLE cycle right after the done pulse.
            run_div(1'b1, a, b, 0, q, r, z, lat, bok, aok);
            n_cmp++;
            if ({q, r, z} !== {eq, er, ez} || lat !== W + 1) begin
                n_fail++;
                $display("FAIL b2b%0d: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=%0d",
                         i, q, r, z, lat, eq, er, ez, W + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r, eq, er;
        logic         z, ez, bok, aok;
        int           lat, seen;
        @(negedge clk);
        signed_op = 1'b0; dividend = 32'd5000; divisor = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b q=%h r=%h z=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d active cycles expected 0", seen);
        end
        model(1'b0, 32'd5000, 32'd9, eq, er, ez);
        run_div(1'b0, 32'd5000, 32'd9, 0, q, r, z, lat, bok, aok);
        n_cmp++;
        if ({q, r, z} !== {eq, er, ez} || lat !== W + 1) begin
            n_fail++;
            $display("FAIL midreset_next_op: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=%0d",
                     q, r, z, lat, eq, er, ez, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
